// File: rtl/fifo_tg_pkg.sv
// Shared types and constants for the FIFO traffic generator: FSM states, mode bit
// positions and the Galois LFSR tap table.
package fifo_tg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StStream,
    StFlush,
    StDone
  } tg_state_e;

  localparam int unsigned ModePatternBit = 0;  // 0: incrementing, 1: LFSR
  localparam int unsigned ModeTrafficBit = 1;  // 0: fill/drain, 1: streaming
  localparam int unsigned MinDataWidth   = 4;
  localparam int unsigned MaxDataWidth   = 32;

  // Right-shifting Galois tap masks for maximal-length sequences; bit p-1 set for tap p.
  function automatic logic [31:0] lfsr_taps(int unsigned width);
    logic [31:0] taps;
    case (width)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_B400;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/fifo_tg_datagen.sv
// Data pattern generator: loads a seed, then steps an incrementing counter or a
// Galois LFSR each time advance is asserted.
module fifo_tg_datagen
  import fifo_tg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  lfsr_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  adv_i,
  output logic [DATA_WIDTH-1:0] value_o
);

  localparam logic [31:0]           TapsFull = lfsr_taps(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] Taps     = TapsFull[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  lfsr_q, lfsr_d;

  always_comb begin
    value_d = value_q;
    lfsr_d  = lfsr_q;
    if (load_i) begin
      lfsr_d = lfsr_i;
      // An all-zero LFSR state never leaves zero.
      if (lfsr_i && (seed_i == '0)) begin
        value_d = DATA_WIDTH'(1);
      end else begin
        value_d = seed_i;
      end
    end else if (adv_i) begin
      if (lfsr_q) begin
        value_d = (value_q >> 1) ^ (value_q[0] ? Taps : '0);
      end else begin
        value_d = value_q + DATA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
      lfsr_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/fifo_traffic_gen.sv
// FIFO traffic generator: writes a pattern into an external FIFO, reads it back with
// one-cycle read latency and counts data mismatches.
module fifo_traffic_gen
  import fifo_tg_pkg::*;
#(
  parameter int unsigned FIFO_ENTRIES = 1024,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [15:0]           length_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  wr_o,
  output logic [DATA_WIDTH-1:0] data_in_o,
  output logic                  rd_o,
  output logic                  oe_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_cnt_o
);

  if (DATA_WIDTH < MinDataWidth || DATA_WIDTH > MaxDataWidth || FIFO_ENTRIES == 0)
  begin : g_param_check
    $error("fifo_traffic_gen: unsupported DATA_WIDTH or FIFO_ENTRIES");
  end

  tg_state_e state_q, state_d;

  logic [15:0] len_q, len_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        cmp_pend_q;
  logic        pass_q, pass_d;
  logic        done_q, done_d;

  logic                  start_acc;
  logic                  writes_rem;
  logic                  reads_rem;
  logic [DATA_WIDTH-1:0] exp_data;

  assign start_acc  = start_i && (state_q == StIdle);
  assign writes_rem = (wr_cnt_q != len_q);
  assign reads_rem  = (rd_cnt_q != len_q);

  assign wr_o = ((state_q == StWrite) || (state_q == StStream)) && writes_rem && !fifo_full_i;
  assign rd_o = ((state_q == StRead) || (state_q == StStream)) && reads_rem && !fifo_empty_i;

  assign oe_o      = (state_q == StRead) || (state_q == StStream) || (state_q == StFlush);
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_cnt_q;

  fifo_tg_datagen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (start_acc),
    .lfsr_i  (mode_i[ModePatternBit]),
    .seed_i  (seed_i),
    .adv_i   (wr_o),
    .value_o (data_in_o)
  );

  // Check-side generator advances once per compare, one cycle behind each read.
  fifo_tg_datagen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (start_acc),
    .lfsr_i  (mode_i[ModePatternBit]),
    .seed_i  (seed_i),
    .adv_i   (cmp_pend_q),
    .value_o (exp_data)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q + {15'b0, wr_o};
    rd_cnt_d  = rd_cnt_q + {15'b0, rd_o};
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    done_d    = 1'b0;

    if (cmp_pend_q && (data_out_i != exp_data) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d     = length_i;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          if (length_i == '0) begin
            state_d = StDone;
          end else if (mode_i[ModeTrafficBit]) begin
            state_d = StStream;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (fifo_full_i || (wr_cnt_d == len_q)) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (rd_cnt_d == len_q) begin
          state_d = StFlush;
        end else if (fifo_empty_i && writes_rem) begin
          state_d = StWrite;
        end
      end
      StStream: begin
        if (rd_cnt_d == len_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StDone;
      end
      StDone: begin
        // The final compare has retired in FLUSH, so err_cnt_q is settled here.
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == '0);
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
      cmp_pend_q <= 1'b0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      cmp_pend_q <= rd_o;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench: a 16-entry FIFO model with one-cycle read latency plus a bus monitor.
module tb_fifo_traffic_gen;

  localparam int Entries = 16;
  localparam int Dw      = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [15:0]   length;
  logic [Dw-1:0] seed;
  logic          wr, rd, oe, busy, done, pass;
  logic [Dw-1:0] data_in;
  logic [Dw-1:0] data_out;
  logic [15:0]   err_cnt;
  logic          fifo_full, fifo_empty;
  logic          corrupt;
  logic          clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_traffic_gen #(
    .FIFO_ENTRIES (Entries),
    .DATA_WIDTH   (Dw)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .mode_i       (mode),
    .length_i     (length),
    .seed_i       (seed),
    .wr_o         (wr),
    .data_in_o    (data_in),
    .rd_o         (rd),
    .oe_o         (oe),
    .fifo_full_i  (fifo_full),
    .fifo_empty_i (fifo_empty),
    .data_out_i   (data_out),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .err_cnt_o    (err_cnt)
  );

  // FIFO model
  logic [Dw-1:0] mem [Entries];
  int wp, rp, cnt, rd_idx;
  logic wr_fire, rd_fire;

  assign fifo_full  = (cnt == Entries);
  assign fifo_empty = (cnt == 0);
  assign wr_fire    = wr && !fifo_full;
  assign rd_fire    = rd && !fifo_empty;

  always @(posedge clk) begin
    if (rst || clr) begin
      wp       <= 0;
      rp       <= 0;
      cnt      <= 0;
      rd_idx   <= 0;
      data_out <= '0;
    end else begin
      if (wr_fire) begin
        mem[wp] <= data_in;
        wp      <= (wp + 1) % Entries;
      end
      if (rd_fire) begin
        data_out <= mem[rp] ^ ((corrupt && rd_idx == 5) ? 16'h0001 : 16'h0000);
        rp       <= (rp + 1) % Entries;
        rd_idx   <= rd_idx + 1;
      end
      cnt <= cnt + (wr_fire ? 1 : 0) - (rd_fire ? 1 : 0);
    end
  end

  // Bus monitor
  int n_wr, n_rd, n_both, n_viol, n_chunk;
  int chunk_len [8];
  logic [Dw-1:0] wlog [64];
  logic last_rd;

  always @(posedge clk) begin
    if (rst || clr) begin
      n_wr    <= 0;
      n_rd    <= 0;
      n_both  <= 0;
      n_viol  <= 0;
      n_chunk <= 0;
      last_rd <= 1'b0;
    end else begin
      n_viol <= n_viol + ((wr && fifo_full) ? 1 : 0) + ((rd && fifo_empty) ? 1 : 0);
      if (wr) begin
        n_wr <= n_wr + 1;
        if (n_wr < 64) wlog[n_wr] <= data_in;
        if (last_rd || n_chunk == 0) begin
          if (n_chunk < 8) chunk_len[n_chunk] <= 1;
          n_chunk <= n_chunk + 1;
          last_rd <= 1'b0;
        end else if (n_chunk <= 8) begin
          chunk_len[n_chunk-1] <= chunk_len[n_chunk-1] + 1;
        end
      end
      if (rd) begin
        n_rd    <= n_rd + 1;
        last_rd <= 1'b1;
      end
      if (wr && rd) n_both <= n_both + 1;
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [15:0] l, input logic [Dw-1:0] s);
    @(negedge clk);
    mode   = m;
    length = l;
    seed   = s;
    start  = 1'b1;
    clr    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wr, rd, oe, busy, done, pass} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {wr, rd, oe, busy, done, pass});
    end
    total++;
    if (err_cnt !== 16'h0 || data_in !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: err=%h data_in=%h want 0/0", err_cnt, data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_incr_basic;
    bit seen;
    start_run(2'b00, 16'd8, 16'h0100);
    total++;
    if (busy !== 1'b1 || wr !== 1'b1 || oe !== 1'b0 || data_in !== 16'h0100) begin
      bad++;
      $display("FAIL incr_first_write: busy=%b wr=%b oe=%b data=%h want 1 1 0 0100",
               busy, wr, oe, data_in);
    end
    wait_done(200, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL incr_done: done not seen want pulse");
    end
    total++;
    if (n_wr !== 8 || n_rd !== 8) begin
      bad++;
      $display("FAIL incr_counts: wr=%0d rd=%0d want 8 8", n_wr, n_rd);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wlog[i] !== 16'h0100 + 16'(i)) begin
        bad++;
        $display("FAIL incr_data[%0d]: got %h want %h", i, wlog[i], 16'h0100 + 16'(i));
      end
    end
    total++;
    if (err_cnt !== 16'h0 || pass !== 1'b1) begin
      bad++;
      $display("FAIL incr_result: err=%h pass=%b want 0 1", err_cnt, pass);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL incr_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_fill_drain;
    bit seen;
    start_run(2'b00, 16'd40, 16'hFFF0);
    wait_done(500, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL fd_done: done not seen want pulse");
    end
    total++;
    if (n_wr !== 40 || n_rd !== 40 || n_viol !== 0) begin
      bad++;
      $display("FAIL fd_counts: wr=%0d rd=%0d viol=%0d want 40 40 0", n_wr, n_rd, n_viol);
    end
    total++;
    if (n_chunk !== 3 || chunk_len[0] !== 16 || chunk_len[1] !== 16 || chunk_len[2] !== 8) begin
      bad++;
      $display("FAIL fd_chunks: n=%0d lens=%0d,%0d,%0d want 3 16,16,8",
               n_chunk, chunk_len[0], chunk_len[1], chunk_len[2]);
    end
    total++;
    if (wlog[15] !== 16'hFFFF || wlog[16] !== 16'h0000) begin
      bad++;
      $display("FAIL fd_wrap: got %h %h want FFFF 0000", wlog[15], wlog[16]);
    end
    total++;
    if (pass !== 1'b1 || err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL fd_result: pass=%b err=%h want 1 0", pass, err_cnt);
    end
  endtask

  task automatic test_lfsr_zero_seed;
    bit seen;
    start_run(2'b01, 16'd3, 16'h0000);
    wait_done(100, seen);
    total++;
    if (!seen || wlog[0] !== 16'h0001 || wlog[1] !== 16'hB400 || wlog[2] !== 16'h5A00) begin
      bad++;
      $display("FAIL lfsr_zero_seed: seen=%b got %h %h %h want 1 0001 B400 5A00",
               seen, wlog[0], wlog[1], wlog[2]);
    end
    total++;
    if (pass !== 1'b1) begin
      bad++;
      $display("FAIL lfsr_zero_pass: pass=%b want 1", pass);
    end
  endtask

  task automatic test_stream;
    bit seen;
    start_run(2'b11, 16'd1000, 16'hACE1);
    wait_done(5000, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stream_done: done not seen want pulse");
    end
    total++;
    if (n_wr !== 1000 || n_rd !== 1000 || n_viol !== 0) begin
      bad++;
      $display("FAIL stream_counts: wr=%0d rd=%0d viol=%0d want 1000 1000 0",
               n_wr, n_rd, n_viol);
    end
    total++;
    if (n_both < 1) begin
      bad++;
      $display("FAIL stream_overlap: both=%0d want >=1", n_both);
    end
    total++;
    if (wlog[0] !== 16'hACE1 || wlog[1] !== 16'hE270 || wlog[2] !== 16'h7138) begin
      bad++;
      $display("FAIL stream_lfsr: got %h %h %h want ACE1 E270 7138", wlog[0], wlog[1], wlog[2]);
    end
    total++;
    if (pass !== 1'b1 || err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL stream_result: pass=%b err=%h want 1 0", pass, err_cnt);
    end
  endtask

  task automatic test_corrupt;
    bit seen;
    corrupt = 1'b1;
    start_run(2'b00, 16'd8, 16'h0100);
    wait_done(200, seen);
    corrupt = 1'b0;
    total++;
    if (!seen || err_cnt !== 16'd1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL corrupt: seen=%b err=%h pass=%b want 1 0001 0", seen, err_cnt, pass);
    end
  endtask

  task automatic test_len_zero;
    start_run(2'b00, 16'd0, 16'h0055);
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL len0_cycle1: done=%b busy=%b want 0 1", done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      bad++;
      $display("FAIL len0_cycle2: done=%b pass=%b want 1 1", done, pass);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || n_wr !== 0 || n_rd !== 0) begin
      bad++;
      $display("FAIL len0_after: done=%b wr=%0d rd=%0d want 0 0 0", done, n_wr, n_rd);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    start_run(2'b11, 16'd1000, 16'h0042);
    repeat (30) @(negedge clk);
    total++;
    if (busy !== 1'b1 || oe !== 1'b1) begin
      bad++;
      $display("FAIL mid_running: busy=%b oe=%b want 1 1", busy, oe);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({wr, rd, oe, busy, done, pass} !== 6'b0 || err_cnt !== 16'h0 || data_in !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset: ctrl=%b err=%h data=%h want 000000 0 0",
               {wr, rd, oe, busy, done, pass}, err_cnt, data_in);
    end
    rst = 1'b0;
    start_run(2'b00, 16'd8, 16'h0100);
    wait_done(200, seen);
    total++;
    if (!seen || pass !== 1'b1 || n_wr !== 8 || n_rd !== 8) begin
      bad++;
      $display("FAIL mid_rerun: seen=%b pass=%b wr=%0d rd=%0d want 1 1 8 8",
               seen, pass, n_wr, n_rd);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    clr     = 1'b0;
    corrupt = 1'b0;
    mode    = 2'b00;
    length  = 16'd0;
    seed    = '0;
    test_reset();
    test_incr_basic();
    test_fill_drain();
    test_lfsr_zero_seed();
    test_stream();
    test_corrupt();
    test_len_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_gen.md
FIFO_TRAFFIC_GEN -- requirements
Module: fifo_traffic_gen

Parameters
- FIFO_ENTRIES, default 1024: depth of the FIFO under test.
- DATA_WIDTH, default 16: FIFO data width; must be >= 4.

Interface
REQ-001 The ports SHALL be as follows, clock and reset first:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that starts a run; ignored while busy_o=1.
- mode_i  in  2  bit0: data pattern (0=incrementing, 1=LFSR); bit1: traffic (0=fill/drain, 1=streaming).
- length_i  in  16  number of words per run; sampled on start.
- seed_i  in  DATA_WIDTH  first data value or LFSR seed; sampled on start.
- wr_o  out  1  FIFO write strobe.
- data_in_o  out  DATA_WIDTH  FIFO write data.
- rd_o  out  1  FIFO read strobe.
- oe_o  out  1  FIFO output enable.
- fifo_full_i  in  1  FIFO full flag.
- fifo_empty_i  in  1  FIFO empty flag.
- data_out_i  in  DATA_WIDTH  FIFO read data.
- busy_o  out  1  a run is in progress.
- done_o  out  1  one-cycle pulse at the end of a run.
- pass_o  out  1  run result: 1 when err_cnt_o=0; held until the next start.
- err_cnt_o  out  16  count of read-data mismatches, saturating.

Function
REQ-002 The FSM SHALL have the states IDLE, WRITE, READ, STREAM, FLUSH and DONE.
REQ-003 On start_i in IDLE, the block SHALL latch mode_i, length_i and seed_i, clear both counters and err_cnt_o, and go to:
- WRITE when mode_i[1]=0;
- STREAM when mode_i[1]=1;
- DONE when length_i=0.
REQ-004 Data generation:
- Incrementing pattern: seed, seed+1, ..., wrapping modulo 2^DATA_WIDTH.
- LFSR pattern: maximal-length Galois LFSR of DATA_WIDTH; a zero seed SHALL be replaced by 1.
REQ-005 The write-side and check-side generators SHALL be separate instances with identical seed and pattern, each advancing only on its own write or compare.
REQ-006 wr_o SHALL be combinational: (state WRITE or STREAM) & writes remaining & !fifo_full_i; a write SHALL never be issued while full.
REQ-007 rd_o SHALL be combinational: (state READ or STREAM) & reads remaining & !fifo_empty_i; a read SHALL never be issued while empty.
REQ-008 The FIFO read latency SHALL be 1 cycle: a read issued in cycle N is compared against data_out_i in cycle N+1.
REQ-009 Each compare SHALL advance the expected generator; a mismatch SHALL increment err_cnt_o, saturating at 0xFFFF.
REQ-010 Fill/drain traffic:
- WRITE goes to READ when fifo_full_i=1 or all writes are done.
- READ goes back to WRITE when fifo_empty_i=1 and writes remain.
- READ goes to FLUSH when all reads are issued.
- Lengths greater than FIFO_ENTRIES are therefore split into chunks.
REQ-011 In STREAM, a write and a read SHALL be allowed in the same cycle; STREAM goes to FLUSH when all reads are issued.
REQ-012 FLUSH SHALL last exactly 1 cycle, to complete the final compare, then go to DONE.
REQ-013 DONE SHALL pulse done_o for 1 cycle, register pass_o=(err_cnt_o==0), and return to IDLE.
REQ-014 busy_o SHALL be 1 in every state except IDLE.
REQ-015 oe_o SHALL be 1 in READ, STREAM and FLUSH.
REQ-016 data_in_o SHALL always present the current write-generator value.
REQ-017 The write and read counters SHALL be 16 bits; a run SHALL end after exactly length_i reads and length_i writes.

Reset
REQ-018 A high rst_i SHALL return the block to IDLE on the next rising edge, with every output at 0, including mid-run.
REQ-019 After reset, both counters, err_cnt_o and pass_o SHALL be 0, and the generators SHALL be idle until the next start_i.

Structure
REQ-020 A shared package fifo_tg_pkg SHALL hold the state enum, the mode bit positions and the LFSR tap-mask function indexed by DATA_WIDTH.
REQ-021 The generator SHALL be one sub-module, fifo_tg_datagen (seed load, advance, pattern select), instantiated twice.

Verification
All scenarios use FIFO_ENTRIES=16 and DATA_WIDTH=16.
REQ-022 mode=00, length=8, seed=0x0100 -> writes 0x0100..0x0107, then 8 reads; done_o pulses; err_cnt_o=0; pass_o=1.
REQ-023 mode=00, length=40 -> fill/drain chunks of 16, 16 and 8; wr_o is never 1 while full and rd_o is never 1 while empty; pass_o=1.
REQ-024 mode=11, length=1000, seed=0xACE1 -> at least one cycle with wr_o and rd_o both 1; exactly 1000 writes and 1000 reads; pass_o=1.
REQ-025 Bench XORs 0x0001 into the 6th read word, mode=00, length=8 -> err_cnt_o=1, pass_o=0.
REQ-026 length=0 -> done_o pulses 2 cycles after start_i; no wr_o or rd_o; pass_o=1.
REQ-027 rst_i asserted mid-STREAM -> all outputs 0 on the next edge; a new start then completes with pass_o=1.
